// File: rtl/lfsr_count_snapshot.sv
// lfsr_count_snapshot: captures {bin[57:0], lfsr[5:0]} on snap and decodes the
// LFSR field to a step index by walking a local LFSR copy from SEED.
// Ports: clk, rst (async high); cnt_in, snap in; out_data/out_err/out_valid
// with out_ready handshake; busy (SEARCH or HOLD); drop_cnt (ignored snaps).
module lfsr_count_snapshot #(
  parameter logic [5:0] SEED   = 6'h3F,
  parameter int         DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       cnt_in,
  input  logic              snap,
  output logic [63:0]       out_data,
  output logic              out_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_HOLD
  } state_t;

  function automatic logic [5:0] lfsr_next(
    input logic [5:0] s
  );
    return {s[4] ^ s[5], s[3:0], s[5]};
  endfunction

  state_t              state_q;
  logic [63:0]         cap_q;
  logic [5:0]          walk_q;
  logic [5:0]          idx_q;
  logic [63:0]         data_q;
  logic                err_q;
  logic                valid_q;
  logic                busy_q;
  logic [DROP_W-1:0]   drop_q;
  logic [DROP_W-1:0]   drop_d;
  logic                hit;
  logic                last;

  // One comparison per cycle; idx 62 is the last reachable step,
  // so a miss there means the captured state is not in the sequence.
  assign hit  = (walk_q == cap_q[5:0]);
  assign last = (idx_q == 6'd62);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
      walk_q  <= SEED;
      idx_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (snap) begin
            cap_q   <= cnt_in;
            walk_q  <= SEED;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (hit) begin
            data_q  <= {cap_q[63:6], idx_q};
            err_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end else if (last) begin
            data_q  <= {cap_q[63:6], 6'h3F};
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end else begin
            walk_q <= lfsr_next(walk_q);
            idx_q  <= idx_q + 6'd1;
          end
        end
        S_HOLD: begin
          if (valid_q && out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Requests arriving while busy are counted, including one that
  // coincides with the completing handshake (busy is still high then).
  always_comb begin
    drop_d = drop_q;
    if (snap && busy_q && !(&drop_q)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign out_data  = data_q;
  assign out_err   = err_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_lfsr_count_snapshot.sv
// tb_lfsr_count_snapshot: directed tests for lfsr_count_snapshot.
// Each task drives its scenario and checks its own results inline.
module tb_lfsr_count_snapshot;

  logic        clk;
  logic        rst;
  logic [63:0] cnt_in;
  logic        snap;
  logic [63:0] out_data;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [7:0]  drop_cnt;

  int total;
  int bad;

  lfsr_count_snapshot #(
    .SEED   (6'h3F),
    .DROP_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .snap      (snap),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ref_next(input logic [5:0] s);
    return {s[4] ^ s[5], s[3], s[2], s[1], s[0], s[5]};
  endfunction

  // Issue one snapshot, wait for valid, check latency/data/err, then
  // complete the handshake and check return to idle.
  task automatic run_snap(
    input string       nm,
    input logic [63:0] c,
    input logic [63:0] exp_data,
    input logic        exp_err,
    input int          exp_lat
  );
    int k;
    @(negedge clk);
    out_ready = 1'b1;
    cnt_in = c;
    snap = 1'b1;
    @(posedge clk);
    #1;
    snap = 1'b0;
    k = 0;
    while (!out_valid && k < 80) begin
      @(posedge clk);
      #1;
      k++;
    end
    total++;
    if (k !== exp_lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", nm, k, exp_lat);
    end
    total++;
    if (out_data !== exp_data) begin
      bad++;
      $display("FAIL %s data got=%h want=%h", nm, out_data, exp_data);
    end
    total++;
    if (out_err !== exp_err) begin
      bad++;
      $display("FAIL %s err got=%b want=%b", nm, out_err, exp_err);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s handshake valid=%b busy=%b want 0 0",
               nm, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    snap = 1'b1;
    out_ready = 1'b0;
    cnt_in = 64'hDEAD_BEEF_0000_00BF;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_data, out_err, out_valid, busy, drop_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_hold data=%h err=%b v=%b busy=%b drop=%h want 0",
               out_data, out_err, out_valid, busy, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    snap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({out_data, out_err, out_valid, busy, drop_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_release data=%h err=%b v=%b busy=%b drop=%h want 0",
               out_data, out_err, out_valid, busy, drop_cnt);
    end
  endtask

  task automatic test_index();
    run_snap("idx0", 64'h0000_0000_0000_00BF, 64'h80, 1'b0, 1);
    run_snap("idx2", 64'h0000_0000_0000_00BE, 64'h82, 1'b0, 3);
  endtask

  task automatic test_sweep();
    logic [5:0]  s;
    logic [57:0] up;
    s = 6'h3F;
    for (int i = 0; i < 63; i++) begin
      up = 58'(i) * 58'h0_0001_0003 + 58'h2A5_0000_0001;
      run_snap("sweep", {up, s}, {up, 6'(i)}, 1'b0, i + 1);
      s = ref_next(s);
    end
    total++;
    if (s !== 6'h3F) begin
      bad++;
      $display("FAIL sweep_period got=%h want=3f", s);
    end
  endtask

  task automatic test_unreachable();
    run_snap("unreach", 64'hFFFF_0000_1234_5640,
             64'hFFFF_0000_1234_567F, 1'b1, 63);
  endtask

  task automatic test_back_to_back();
    logic [63:0] held;
    int k;
    total++;
    if (drop_cnt !== 8'h00) begin
      bad++;
      $display("FAIL drop_start got=%h want=00", drop_cnt);
    end
    @(negedge clk);
    out_ready = 1'b0;
    cnt_in = 64'h0123_4567_89AB_CD3F;
    snap = 1'b1;
    @(posedge clk);
    #1;
    snap = 1'b0;
    k = 0;
    while (!out_valid && k < 80) begin
      @(posedge clk);
      #1;
      k++;
    end
    total++;
    if (out_data !== 64'h0123_4567_89AB_CD00 || k !== 1) begin
      bad++;
      $display("FAIL bp_result data=%h lat=%0d want 0123456789abcd00 1",
               out_data, k);
    end
    held = 64'h0123_4567_89AB_CD00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cnt_in = 64'hAAAA_5555_AAAA_551F;
      snap = (c % 5 == 2);
      @(posedge clk);
      #1;
      snap = 1'b0;
      total++;
      if (out_data !== held || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_stable c=%0d data=%h v=%b", c, out_data, out_valid);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    snap = 1'b1;
    @(posedge clk);
    #1;
    snap = 1'b0;
    total++;
    if (drop_cnt !== 8'd5) begin
      bad++;
      $display("FAIL bp_drops got=%0d want=5", drop_cnt);
    end
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle busy=%b v=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    out_ready = 1'b0;
    cnt_in = 64'h0000_0000_0000_00C0;
    snap = 1'b1;
    repeat (301) @(posedge clk);
    #1;
    total++;
    if (drop_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL sat_drop got=%h want=ff", drop_cnt);
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'hFF || out_err !== 1'b1) begin
      bad++;
      $display("FAIL sat_hold v=%b data=%h err=%b want 1 ff 1",
               out_valid, out_data, out_err);
    end
    @(negedge clk);
    snap = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || drop_cnt !== 8'hFF) begin
      bad++;
      $display("FAIL sat_idle busy=%b drop=%h want 0 ff", busy, drop_cnt);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    out_ready = 1'b1;
    cnt_in = 64'h5555_5555_5555_5540;
    snap = 1'b1;
    @(posedge clk);
    #1;
    snap = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_pre busy=%b v=%b want 1 0", busy, out_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || drop_cnt !== 8'h00) begin
      bad++;
      $display("FAIL mid_async busy=%b v=%b drop=%h want 0 0 00",
               busy, out_valid, drop_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    run_snap("post_rst", 64'h0000_0000_0000_00BE, 64'h82, 1'b0, 3);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    snap = 1'b0;
    out_ready = 1'b0;
    cnt_in = '0;
    test_reset();
    test_index();
    test_sweep();
    test_unreachable();
    test_back_to_back();
    test_saturate();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
